// File: rtl/iic_slave_regs.sv
// iic_slave_regs
//   I2C target with 16-bit register addressing and 8-bit data. Answers
//   2-byte-address / 1-byte-data transactions and exposes a simple
//   register-file port so configuration registers can be programmed over
//   the same bus.
//
// Parameters
//   DEV_ADDR  7-bit device address (write form DEV_ADDR<<1)
//   FILT_LEN  consecutive equal samples needed before a filtered level moves
//
// Ports
//   clk, rst_n      system clock (>= 20x SCL rate), async active-low reset
//   scl, sda_in     bus pad inputs
//   sda_out         SDA drive value, constant 0 (open-drain)
//   sda_out_en      1 = pull SDA low
//   reg_addr        current register address
//   reg_wdata       write data, valid while reg_we = 1
//   reg_we          one-cycle write strobe
//   reg_re          one-cycle read request
//   reg_rdata       read data, valid 1 clk after reg_re
//   busy            address-matched transaction in progress
module iic_slave_regs #(
    parameter logic [6:0]  DEV_ADDR = 7'h2B,
    parameter int unsigned FILT_LEN = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl,
    input  logic        sda_in,
    output logic        sda_out,
    output logic        sda_out_en,
    output logic [15:0] reg_addr,
    output logic [7:0]  reg_wdata,
    output logic        reg_we,
    output logic        reg_re,
    input  logic [7:0]  reg_rdata,
    output logic        busy
);

    localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    typedef enum logic [3:0] {
        IDLE, DEV, ACK_DEV, AH, ACK_AH, AL, ACK_AL, WR, ACK_WR, RD, RD_ACK, WAIT
    } state_t;

    state_t state, state_n;

    // Input conditioning: bit 1 = SCL, bit 0 = SDA
    logic [1:0]    sync1, sync2, filt, filt_d;
    logic [CW-1:0] fcnt [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '1;
            sync2   <= '1;
            filt    <= '1;
            filt_d  <= '1;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
        end else begin
            sync1  <= {scl, sda_in};
            sync2  <= sync1;
            filt_d <= filt;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == CW'(FILT_LEN - 1)) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + CW'(1);
                end
            end
        end
    end

    logic scl_f, sda_f, scl_d, sda_d;
    logic scl_rise, scl_fall, start_c, stop_c;

    assign scl_f    = filt[1];
    assign sda_f    = filt[0];
    assign scl_d    = filt_d[1];
    assign sda_d    = filt_d[0];
    assign scl_rise = scl_f & ~scl_d;
    assign scl_fall = ~scl_f & scl_d;
    // SCL must be high on both sides of the SDA edge to count as a bus condition
    assign start_c  = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_c   = scl_f & scl_d & ~sda_d & sda_f;

    // Datapath state
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic [7:0] tx;
    logic       ack_rise;   // 9th SCL rise of the ACK slot has been seen
    logic       rw;
    logic       re_pend;
    logic       re_d;

    logic [7:0] rx_byte;
    logic       last_bit;
    logic       addr_match;

    assign rx_byte    = {shreg, sda_f};
    assign last_bit   = (bit_cnt == 3'd7);
    assign addr_match = (rx_byte[7:1] == DEV_ADDR);
    assign sda_out    = 1'b0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        if (start_c) begin
            state_n = DEV;
        end else if (stop_c) begin
            state_n = IDLE;
        end else begin
            case (state)
                DEV:     if (scl_rise && last_bit) state_n = addr_match ? ACK_DEV : WAIT;
                AH:      if (scl_rise && last_bit) state_n = ACK_AH;
                AL:      if (scl_rise && last_bit) state_n = ACK_AL;
                WR:      if (scl_rise && last_bit) state_n = ACK_WR;
                ACK_DEV: if (scl_fall && ack_rise) state_n = rw ? RD : AH;
                ACK_AH:  if (scl_fall && ack_rise) state_n = AL;
                ACK_AL:  if (scl_fall && ack_rise) state_n = WR;
                ACK_WR:  if (scl_fall && ack_rise) state_n = WR;
                RD:      if (scl_rise && last_bit) state_n = RD_ACK;
                RD_ACK:  if (scl_rise)             state_n = sda_f ? WAIT : RD;
                default: state_n = state;
            endcase
        end
    end

    // Output decode: strobes and next SDA drive value
    logic we_set, re_set, sda_en_n;

    always_comb begin
        we_set   = (state == WR) && scl_rise && last_bit;
        re_set   = re_pend ||
                   ((state == DEV) && scl_rise && last_bit && addr_match && sda_f);
        sda_en_n = sda_out_en;
        if (start_c || stop_c) begin
            sda_en_n = 1'b0;
        end else if (scl_fall) begin
            case (state)
                ACK_DEV, ACK_AH, ACK_AL, ACK_WR: begin
                    if (!ack_rise)
                        sda_en_n = 1'b1;
                    else if (state == ACK_DEV && rw)
                        sda_en_n = ~tx[7];       // ACK release and first read bit share this edge
                    else
                        sda_en_n = 1'b0;
                end
                RD:      sda_en_n = ~tx[3'd7 - bit_cnt];
                default: sda_en_n = 1'b0;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_out_en <= 1'b0;
            reg_addr   <= '0;
            reg_wdata  <= '0;
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
            busy       <= 1'b0;
            bit_cnt    <= '0;
            shreg      <= '0;
            tx         <= '0;
            ack_rise   <= 1'b0;
            rw         <= 1'b0;
            re_pend    <= 1'b0;
            re_d       <= 1'b0;
        end else begin
            sda_out_en <= sda_en_n;
            reg_we     <= we_set;
            reg_re     <= re_set;
            re_d       <= reg_re;
            re_pend    <= 1'b0;
            if (we_set) reg_wdata <= rx_byte;
            if (re_d)   tx <= reg_rdata;
            if (reg_we) reg_addr <= reg_addr + 16'd1;

            if (start_c || stop_c) begin
                bit_cnt  <= '0;
                ack_rise <= 1'b0;
                if (stop_c) busy <= 1'b0;
            end else begin
                case (state)
                    DEV, AH, AL, WR: begin
                        if (scl_rise) begin
                            shreg   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 3'd1;   // wraps to 0 for the ACK slot
                            if (last_bit) begin
                                ack_rise <= 1'b0;
                                if (state == DEV) begin
                                    busy <= addr_match;
                                    if (addr_match) rw <= sda_f;
                                end
                                if (state == AH) reg_addr[15:8] <= rx_byte;
                                if (state == AL) reg_addr[7:0]  <= rx_byte;
                            end
                        end
                    end
                    ACK_DEV, ACK_AH, ACK_AL, ACK_WR: begin
                        if (scl_rise)
                            ack_rise <= 1'b1;
                        else if (scl_fall && ack_rise)
                            ack_rise <= 1'b0;
                    end
                    RD: begin
                        if (scl_rise) bit_cnt <= bit_cnt + 3'd1;
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            if (!sda_f) begin
                                reg_addr <= reg_addr + 16'd1;
                                re_pend  <= 1'b1;        // request issued once the new address is visible
                            end else begin
                                busy <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iic_slave_regs.sv
`timescale 1ns/1ps
module tb_iic_slave_regs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_line;
    logic        sda_out, sda_out_en, reg_we, reg_re, busy;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata = '0;
    logic        glitch = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Open-drain bus: either side can pull low
    assign sda_line = sda_m & (sda_out_en ? sda_out : 1'b1);

    always #50 clk = ~clk;

    iic_slave_regs #(.DEV_ADDR(7'h2B), .FILT_LEN(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl        (scl),
        .sda_in     (sda_line),
        .sda_out    (sda_out),
        .sda_out_en (sda_out_en),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_we     (reg_we),
        .reg_re     (reg_re),
        .reg_rdata  (reg_rdata),
        .busy       (busy)
    );

    // Register-file content seen by reads: a fixed function of the address
    function automatic logic [7:0] rd_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    always @(posedge clk) if (reg_re) reg_rdata <= rd_val(reg_addr);

    // Strobe capture and bus-rule monitors
    logic [23:0] we_q[$], exp_we[$];
    logic [15:0] re_q[$], exp_re[$];
    logic        we_prev = 1'b0, re_prev = 1'b0, en_prev = 1'b0, en_seen = 1'b0;
    int unsigned n_wide = 0, n_sda_hi = 0;

    always @(negedge clk) begin
        if (reg_we) we_q.push_back({reg_addr, reg_wdata});
        if (reg_re) re_q.push_back(reg_addr);
        if ((reg_we && we_prev) || (reg_re && re_prev)) n_wide++;
        if (sda_out_en) en_seen = 1'b1;
        if (rst_n && scl && (sda_out_en !== en_prev)) n_sda_hi++;
        we_prev = reg_we;
        re_prev = reg_re;
        en_prev = sda_out_en;
    end

    logic [15:0] cur = '0;          // model of the register address pointer
    logic [7:0]  wbuf [0:7];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL period starting and ending with SCL low; s = SDA seen mid-high
    task automatic clock_bit(input logic b, input logic drive, output logic s);
        if (glitch) begin tick(3); scl = 1'b1; tick(1); scl = 1'b0; tick(2); end
        else tick(6);
        sda_m = drive ? b : 1'b1;
        tick(6);
        scl = 1'b1;
        if (glitch) begin tick(3); scl = 1'b0; tick(1); scl = 1'b1; tick(2); end
        else tick(6);
        s = sda_line;
        if (glitch && drive) begin tick(2); sda_m = ~b; tick(1); sda_m = b; tick(3); end
        else tick(6);
        scl = 1'b0;
    endtask

    task automatic i2c_start();
        tick(6); sda_m = 1'b1;
        tick(6); scl = 1'b1;
        tick(8); sda_m = 1'b0;
        tick(8); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        tick(6); sda_m = 1'b0;
        tick(6); scl = 1'b1;
        tick(8); sda_m = 1'b1;
        tick(12);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int unsigned i = 0; i < 8; i++) clock_bit(b[7-i], 1'b1, s);
        clock_bit(1'b1, 1'b0, s);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic ack, output logic [7:0] b);
        logic s;
        for (int unsigned i = 0; i < 8; i++) begin
            clock_bit(1'b1, 1'b0, s);
            b[7-i] = s;
        end
        clock_bit(~ack, 1'b1, s);
    endtask

    task automatic check_strobes();
        check_val("we_count", we_q.size(), exp_we.size());
        while (we_q.size() > 0 && exp_we.size() > 0)
            check_val("we_addr_data", we_q.pop_front(), exp_we.pop_front());
        check_val("re_count", re_q.size(), exp_re.size());
        while (re_q.size() > 0 && exp_re.size() > 0)
            check_val("re_addr", re_q.pop_front(), exp_re.pop_front());
        we_q.delete(); exp_we.delete(); re_q.delete(); exp_re.delete();
    endtask

    task automatic set_addr(input logic [15:0] a);
        logic ack;
        i2c_start();
        send_byte(8'h56, ack);  check_val("ack_dev_w", ack, 1);
        check_val("busy_set", busy, 1);
        send_byte(a[15:8], ack); check_val("ack_ah", ack, 1);
        send_byte(a[7:0], ack);  check_val("ack_al", ack, 1);
        cur = a;
    endtask

    task automatic write_txn(input logic [15:0] a, input int unsigned n);
        logic ack;
        set_addr(a);
        for (int unsigned i = 0; i < n; i++) begin
            send_byte(wbuf[i], ack);
            check_val("ack_wdata", ack, 1);
            exp_we.push_back({cur, wbuf[i]});
            cur = cur + 16'd1;
        end
        i2c_stop();
        check_val("busy_after_stop", busy, 0);
        check_val("addr_after_wr", reg_addr, cur);
        check_strobes();
    endtask

    task automatic read_txn(input logic [15:0] a, input int unsigned k);
        logic ack, last;
        logic [7:0] b;
        set_addr(a);
        i2c_start();
        send_byte(8'h57, ack);
        check_val("ack_dev_r", ack, 1);
        for (int unsigned j = 0; j < k; j++) begin
            last = (j == k - 1);
            recv_byte(~last, b);
            check_val("rd_data", b, rd_val(cur));
            exp_re.push_back(cur);
            if (!last) cur = cur + 16'd1;
        end
        check_val("sda_released_nack", sda_out_en, 0);
        check_val("busy_after_nack", busy, 0);
        i2c_stop();
        check_val("addr_after_rd", reg_addr, cur);
        check_strobes();
    endtask

    initial begin
        #8_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        ack, s;
        logic [15:0] a;
        logic [7:0]  db;
        int unsigned n;

        // Reset values
        tick(3);
        check_val("rst_sda_out", sda_out, 0);
        check_val("rst_sda_out_en", sda_out_en, 0);
        check_val("rst_reg_addr", reg_addr, 0);
        check_val("rst_reg_wdata", reg_wdata, 0);
        check_val("rst_reg_we", reg_we, 0);
        check_val("rst_reg_re", reg_re, 0);
        check_val("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick(10);

        // Single write 0x1234 <= 0xA5
        wbuf[0] = 8'hA5;
        write_txn(16'h1234, 1);

        // Read 3 bytes from 0x0010
        read_txn(16'h0010, 3);

        // Wrong device address: ignored entirely
        en_seen = 1'b0;
        i2c_start();
        send_byte(8'h58, ack);
        check_val("nack_wrong_dev", ack, 0);
        check_val("busy_wrong_dev", busy, 0);
        send_byte(8'h00, ack);
        send_byte(8'h11, ack);
        i2c_stop();
        check_val("sda_idle_wrong_dev", en_seen, 0);
        check_val("addr_kept_wrong_dev", reg_addr, cur);
        check_strobes();

        // Burst across the address wrap
        wbuf[0] = 8'h01; wbuf[1] = 8'h02;
        write_txn(16'hFFFF, 2);

        // 1-clk glitches on SCL and SDA
        glitch = 1'b1;
        wbuf[0] = 8'h3C; wbuf[1] = 8'hC3;
        write_txn(16'h4321, 2);
        read_txn(16'h0100, 2);
        glitch = 1'b0;

        // Asynchronous reset inside a data byte
        set_addr(16'h0030);
        db = 8'hC3;
        for (int unsigned i = 0; i < 5; i++) clock_bit(db[7-i], 1'b1, s);
        #7 rst_n = 1'b0;
        #1;
        check_val("async_rst_busy", busy, 0);
        check_val("async_rst_sda_en", sda_out_en, 0);
        check_val("async_rst_addr", reg_addr, 0);
        tick(4);
        rst_n = 1'b1;
        cur = '0;
        tick(20);
        check_val("abort_no_we", we_q.size(), 0);
        we_q.delete(); re_q.delete();
        wbuf[0] = 8'h5A;
        write_txn(16'h0020, 1);

        // Randomized transactions
        for (int unsigned t = 0; t < 10; t++) begin
            a = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            n = $urandom_range(1, 3);
            if ($urandom_range(0, 1) == 1) begin
                for (int unsigned i = 0; i < n; i++) wbuf[i] = 8'($urandom);
                write_txn(a, n);
            end else begin
                read_txn(a, n);
            end
        end

        check_val("strobe_width", n_wide, 0);
        check_val("sda_change_scl_high", n_sda_hi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
